dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory (1-cycle read latency, registered address) between two requesters.
- Port 0 is the processor data port; port 1 is a host/loader port (debug, memory preload from SW/KEY).
- Generates per-port Waitreq, so the processor's DataWaitreq is driven by this block instead of being tied to 0.
- Round-robin arbitration; one memory transaction in flight at a time.

Parameters:
WORD_SIZE, 16, data and requester address width
ADDR_WIDTH, 12, memory address width; requester address truncated to low ADDR_WIDTH bits

Ports:
Clock  in  1  system clock, all state on rising edge
Reset  in  1  synchronous, active-low reset
P0_Read  in  1  port 0 read request, held until P0_Waitreq low
P0_Write  in  1  port 0 write request, held until P0_Waitreq low
P0_Addr  in  WORD_SIZE  port 0 address
P0_WrData  in  WORD_SIZE  port 0 write data
P0_RdData  out  WORD_SIZE  port 0 read data, valid in the cycle P0_Waitreq is low for a read
P0_Waitreq  out  1  port 0 stall
P1_Read, P1_Write, P1_Addr, P1_WrData, P1_RdData, P1_Waitreq: same as port 0, for port 1
MemAddr  out  ADDR_WIDTH  memory address
MemWrData  out  WORD_SIZE  memory write data
MemWren  out  1  memory write enable
MemQ  in  WORD_SIZE  memory read data, one cycle after address
Grant  out  1  port owning the current transaction (valid when Busy)
Busy  out  1  high in ACCESS and RDATA

Behaviour:
- FSM states:
  - IDLE: if any request is pending, register the winner into Grant, latch its Addr/WrData/op, and go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: drive MemAddr, MemWrData and MemWren (=1 only for writes) from the latched values.
    - Write: the granted port's Waitreq is low this cycle; go to IDLE.
    - Read: go to RDATA.
  - RDATA: Px_RdData = MemQ for the granted port; its Waitreq is low; go to IDLE.
- Latency from request seen in IDLE:
  - Write completes in the 2nd cycle (Waitreq low in ACCESS).
  - Read completes in the 3rd cycle (Waitreq low in RDATA).
- Waitreq(x) = (Px_Read | Px_Write) & ~(completing cycle for x). It is low when port x is not requesting.
- Arbitration:
  - Round-robin pointer names the port that wins a tie. After any grant, the pointer moves to the other port.
  - A lone requester always wins.
  - Worst-case wait for a port is one foreign transaction (≤3 cycles) plus its own.
- Simultaneous Read and Write asserted on the same port: treated as a write.
- Request dropped before completion: the transaction still runs to completion in memory (a write is still committed); the completion pulse is ignored.
- Latched request values are used in ACCESS. Addr/WrData changes after the grant cycle do not affect the transaction.
- Px_RdData holds its last value outside RDATA. Its reset value is 0.
- Outputs when idle: MemAddr holds its last value; MemWren=0.
- Back-to-back: after completion the FSM returns to IDLE, so there is always one idle/arbitration cycle between transactions.
- Reset (Reset=0 sampled at an edge):
  - State=IDLE, pointer=port 0, Grant=0, Busy=0, P0/P1_RdData=0.
  - MemWren is combinationally forced 0 while Reset=0, so no write commits in a cycle with reset asserted, including reset mid-ACCESS.
  - Waitreq follows its formula; no completion pulse during reset.
- Address: MemAddr = latched Addr[ADDR_WIDTH-1:0]. Upper bits are ignored (wrap-around aliasing).

Test Plan:
- Reset then P0_Write addr 0x005 data 0x1234: MemWren=1 with MemAddr=0x005 in cycle 2, P0_Waitreq low in cycle 2; then P0_Read 0x005 gives P0_RdData=0x1234 with Waitreq low in cycle 3.
- P0_Read 0x010 and P1_Read 0x020 asserted in the same cycle after reset: port 0 served first (Grant=0), then port 1 (Grant=1); P1_Waitreq stays high until its RDATA cycle.
- Both ports issue continuous requests for 8 transactions: grants alternate 0,1,0,1…; neither port waits more than 6 cycles.
- P1_Write addr 0x1005 data 0xBEEF, then P0_Read 0x005: returns 0xBEEF (aliasing).
- P0_Write in progress, Reset=0 asserted during the ACCESS cycle: MemWren=0, memory word unchanged; after release state=IDLE, Busy=0, all RdData=0.
- P1_Read and P1_Write asserted together, addr 0x003 data 0x00FF: a write occurs; a subsequent read returns 0x00FF.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous data memory between the
// processor data port (0) and a host/loader port (1); one transaction in flight.
module dmem_arbiter #(
  parameter int WORD_SIZE  = 16,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  P0_Read,
  input  logic                  P0_Write,
  input  logic [WORD_SIZE-1:0]  P0_Addr,
  input  logic [WORD_SIZE-1:0]  P0_WrData,
  output logic [WORD_SIZE-1:0]  P0_RdData,
  output logic                  P0_Waitreq,
  input  logic                  P1_Read,
  input  logic                  P1_Write,
  input  logic [WORD_SIZE-1:0]  P1_Addr,
  input  logic [WORD_SIZE-1:0]  P1_WrData,
  output logic [WORD_SIZE-1:0]  P1_RdData,
  output logic                  P1_Waitreq,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [WORD_SIZE-1:0]  MemWrData,
  output logic                  MemWren,
  input  logic [WORD_SIZE-1:0]  MemQ,
  output logic                  Grant,
  output logic                  Busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;

  state_t                  state, state_nxt;
  logic                    ptr;
  logic                    grant;
  logic                    req0, req1;
  logic                    take, win;
  logic                    done0, done1;
  logic                    rdv0, rdv1;
  logic [WORD_SIZE-1:0]    rd_hold0, rd_hold1;
  logic [ADDR_WIDTH-1:0]   addr_p0;
  logic [WORD_SIZE-1:0]    wrdata_p0;
  logic                    wr_p0;
  logic                    unused_addr_hi;

  assign req0 = P0_Read | P0_Write;
  assign req1 = P1_Read | P1_Write;
  assign unused_addr_hi = ^{P0_Addr[WORD_SIZE-1:ADDR_WIDTH], P1_Addr[WORD_SIZE-1:ADDR_WIDTH]};

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    win       = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    rdv0      = 1'b0;
    rdv1      = 1'b0;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          take      = 1'b1;
          win       = (req0 & req1) ? ptr : req1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (wr_p0) begin
          done0     = ~grant;
          done1     = grant;
          state_nxt = IDLE;
        end else begin
          state_nxt = RDATA;
        end
      end
      RDATA: begin
        done0     = ~grant;
        done1     = grant;
        rdv0      = ~grant;
        rdv1      = grant;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // No completion is reported while reset is held.
    done0 = done0 & Reset;
    done1 = done1 & Reset;
    rdv0  = rdv0 & Reset;
    rdv1  = rdv1 & Reset;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      grant    <= 1'b0;
      rd_hold0 <= '0;
      rd_hold1 <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        grant <= win;
        ptr   <= ~win;
      end
      if (rdv0) rd_hold0 <= MemQ;
      if (rdv1) rd_hold1 <= MemQ;
    end
  end

  // Grant stage: winner's request captured here, used unchanged in ACCESS
  always_ff @(posedge Clock) begin
    if (take) begin
      addr_p0   <= win ? P1_Addr[ADDR_WIDTH-1:0] : P0_Addr[ADDR_WIDTH-1:0];
      wrdata_p0 <= win ? P1_WrData : P0_WrData;
      wr_p0     <= win ? P1_Write : P0_Write;
    end
  end

  assign MemAddr    = addr_p0;
  assign MemWrData  = wrdata_p0;
  assign MemWren    = (state == ACCESS) & wr_p0 & Reset;
  assign Busy       = (state != IDLE);
  assign Grant      = grant;
  assign P0_Waitreq = req0 & ~done0;
  assign P1_Waitreq = req1 & ~done1;
  assign P0_RdData  = rdv0 ? MemQ : rd_hold0;
  assign P1_RdData  = rdv1 ? MemQ : rd_hold1;

endmodule
